// File: rtl/semaforo_pkg.sv
// Shared types and constants for the traffic-light controller and its monitor.
package semaforo_pkg;

    typedef enum logic [2:0] {
        F_DIA0   = 3'd0,
        F_DIA1   = 3'd1,
        F_DIA2   = 3'd2,
        F_DIA3   = 3'd3,
        F_NOITE0 = 3'd4,
        F_NOITE1 = 3'd5,
        F_INV    = 3'd7
    } fase_t;

    // Required dwell, in clock cycles, for each day phase
    localparam logic [2:0] DWELL_DIA0 = 3'd4;
    localparam logic [2:0] DWELL_DIA1 = 3'd1;
    localparam logic [2:0] DWELL_DIA2 = 3'd3;
    localparam logic [2:0] DWELL_DIA3 = 3'd1;

    // Fault codes; lower-numbered checks are not necessarily higher priority
    localparam logic [2:0] ERR_NENHUM = 3'd0;
    localparam logic [2:0] ERR_VERDE  = 3'd1;
    localparam logic [2:0] ERR_PADRAO = 3'd2;
    localparam logic [2:0] ERR_ORDEM  = 3'd3;
    localparam logic [2:0] ERR_CURTO  = 3'd4;
    localparam logic [2:0] ERR_LONGO  = 3'd5;
    localparam logic [2:0] ERR_NOITE  = 3'd6;

    function automatic logic eh_dia(input fase_t f);
        return (f == F_DIA0) || (f == F_DIA1) || (f == F_DIA2) || (f == F_DIA3);
    endfunction

    function automatic logic eh_noite(input fase_t f);
        return (f == F_NOITE0) || (f == F_NOITE1);
    endfunction

    function automatic logic [2:0] dwell_req(input fase_t f);
        logic [2:0] r;
        r = '0;
        case (f)
            F_DIA0:  r = DWELL_DIA0;
            F_DIA1:  r = DWELL_DIA1;
            F_DIA2:  r = DWELL_DIA2;
            F_DIA3:  r = DWELL_DIA3;
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic fase_t prox_dia(input fase_t f);
        fase_t r;
        r = F_INV;
        case (f)
            F_DIA0:  r = F_DIA1;
            F_DIA1:  r = F_DIA2;
            F_DIA2:  r = F_DIA3;
            F_DIA3:  r = F_DIA0;
            default: r = F_INV;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/semaforo_decod.sv
// Combinational lamp-pattern decoder: six lamps in, phase out.
module semaforo_decod
    import semaforo_pkg::*;
(
    input  logic  verdeA,
    input  logic  amareloA,
    input  logic  vermelhoA,
    input  logic  verdeB,
    input  logic  amareloB,
    input  logic  vermelhoB,
    output fase_t fase
);

    logic [5:0] lamps;

    assign lamps = {vermelhoA, amareloA, verdeA, vermelhoB, amareloB, verdeB};

    // Map each legal {red,amber,green} A;B pattern to its phase
    always_comb begin
        fase = F_INV;
        case (lamps)
            6'b001_100: fase = F_DIA0;
            6'b010_100: fase = F_DIA1;
            6'b100_001: fase = F_DIA2;
            6'b100_010: fase = F_DIA3;
            6'b010_010: fase = F_NOITE0;
            6'b000_000: fase = F_NOITE1;
            default:    fase = F_INV;
        endcase
    end

endmodule

// File: rtl/semaforo_monitor.sv
// Traffic-light monitor: decodes the lamps, checks phase order and dwell,
// latches the first fault and counts completed day cycles.
module semaforo_monitor
    import semaforo_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       modo,
    input  logic       verdeA,
    input  logic       amareloA,
    input  logic       vermelhoA,
    input  logic       verdeB,
    input  logic       amareloB,
    input  logic       vermelhoB,
    output logic [2:0] fase,
    output logic       erro,
    output logic [2:0] cod_erro,
    output logic [7:0] ciclos
);

    // GRACA: checks off; SINC: accept whatever phase shows; ATIVO: full checking
    typedef enum logic [1:0] {
        CHK_GRACA,
        CHK_SINC,
        CHK_ATIVO
    } chk_t;

    fase_t      atual;
    fase_t      fase_q;
    chk_t       estado;
    logic       modo_q;
    logic [2:0] dwell;
    logic       parcial;
    logic       graca;
    logic       sinc;
    logic       troca;
    logic [2:0] cod_novo;
    logic       ciclo_ok;

    semaforo_decod u_decod (
        .verdeA    (verdeA),
        .amareloA  (amareloA),
        .vermelhoA (vermelhoA),
        .verdeB    (verdeB),
        .amareloB  (amareloB),
        .vermelhoB (vermelhoB),
        .fase      (atual)
    );

    assign graca    = (estado == CHK_GRACA) || (modo != modo_q);
    assign sinc     = (estado == CHK_SINC);
    assign troca    = (atual != fase_q);
    assign ciclo_ok = !graca && !sinc && (fase_q == F_DIA3) && (atual == F_DIA0)
                      && (cod_novo == ERR_NENHUM);
    assign fase     = fase_q;

    // Classify the current sample against the previous phase, highest priority first
    always_comb begin
        cod_novo = ERR_NENHUM;
        if (verdeA && verdeB)
            cod_novo = ERR_VERDE;
        else if ((atual == F_INV) || (eh_noite(atual) && !modo))
            cod_novo = ERR_PADRAO;
        else if ((eh_dia(atual) && modo) || (!parcial && !troca && eh_noite(atual)))
            cod_novo = ERR_NOITE;
        else if (!sinc && troca && eh_dia(fase_q) && eh_dia(atual)
                 && (atual != prox_dia(fase_q)))
            cod_novo = ERR_ORDEM;
        else if (!sinc && !parcial && troca && eh_dia(fase_q)
                 && (dwell < dwell_req(fase_q)))
            cod_novo = ERR_CURTO;
        else if (!parcial && !troca && eh_dia(atual) && (dwell >= dwell_req(atual)))
            cod_novo = ERR_LONGO;
    end

    // Phase register, dwell counter, sync FSM, fault latch and cycle counter
    always_ff @(posedge clk) begin
        if (reset) begin
            fase_q   <= F_INV;
            estado   <= CHK_GRACA;
            modo_q   <= modo;
            dwell    <= '0;
            parcial  <= 1'b0;
            erro     <= 1'b0;
            cod_erro <= '0;
            ciclos   <= '0;
        end else begin
            fase_q <= atual;
            modo_q <= modo;

            if (troca)
                dwell <= 3'd1;
            else if (dwell != '1)
                dwell <= dwell + 3'd1;

            // The phase in force around a grace/sync point may be partial, so
            // its dwell is not judged until the next real transition.
            if (graca) begin
                estado  <= CHK_SINC;
                parcial <= 1'b1;
            end else if (sinc) begin
                estado  <= CHK_ATIVO;
                parcial <= 1'b1;
            end else if (troca) begin
                parcial <= 1'b0;
            end

            if (!graca && !erro && (cod_novo != ERR_NENHUM)) begin
                erro     <= 1'b1;
                cod_erro <= cod_novo;
            end

            if (ciclo_ok && !erro && (ciclos != '1))
                ciclos <= ciclos + 8'd1;
        end
    end

endmodule

// File: tb/tb_semaforo_monitor.sv
// Scoreboard bench for semaforo_monitor: the driver pushes hand-computed
// expectations, the monitor pops one per clock after the DUT updates.
module tb_semaforo_monitor;

    localparam logic [5:0] P_D0  = 6'b001_100;
    localparam logic [5:0] P_D1  = 6'b010_100;
    localparam logic [5:0] P_D2  = 6'b100_001;
    localparam logic [5:0] P_D3  = 6'b100_010;
    localparam logic [5:0] P_N0  = 6'b010_010;
    localparam logic [5:0] P_N1  = 6'b000_000;
    localparam logic [5:0] P_VV  = 6'b001_001;
    localparam logic [5:0] P_BAD = 6'b111_111;

    localparam logic [2:0] E_D0  = 3'd0;
    localparam logic [2:0] E_D1  = 3'd1;
    localparam logic [2:0] E_D2  = 3'd2;
    localparam logic [2:0] E_D3  = 3'd3;
    localparam logic [2:0] E_N0  = 3'd4;
    localparam logic [2:0] E_N1  = 3'd5;
    localparam logic [2:0] E_INV = 3'd7;

    typedef struct {
        int         seg;
        int         idx;
        logic [2:0] fase;
        logic       erro;
        logic [2:0] cod;
        logic [7:0] cy;
    } exp_t;

    logic       clk;
    logic       reset;
    logic       modo;
    logic [5:0] lamps;
    logic       verdeA, amareloA, vermelhoA, verdeB, amareloB, vermelhoB;
    logic [2:0] fase;
    logic       erro;
    logic [2:0] cod_erro;
    logic [7:0] ciclos;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   seg     = 0;
    int   idx     = 0;

    assign {vermelhoA, amareloA, verdeA, vermelhoB, amareloB, verdeB} = lamps;

    semaforo_monitor dut (
        .clk       (clk),
        .reset     (reset),
        .modo      (modo),
        .verdeA    (verdeA),
        .amareloA  (amareloA),
        .vermelhoA (vermelhoA),
        .verdeB    (verdeB),
        .amareloB  (amareloB),
        .vermelhoB (vermelhoB),
        .fase      (fase),
        .erro      (erro),
        .cod_erro  (cod_erro),
        .ciclos    (ciclos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic [5:0] l, input logic md, input logic rst,
                        input logic [2:0] ef, input logic ee,
                        input logic [2:0] ec, input logic [7:0] ecy);
        exp_t e;
        @(negedge clk);
        lamps = l;
        modo  = md;
        reset = rst;
        idx++;
        e.seg  = seg;
        e.idx  = idx;
        e.fase = ef;
        e.erro = ee;
        e.cod  = ec;
        e.cy   = ecy;
        sb.push_back(e);
    endtask

    task automatic legal_cycle(input logic [7:0] cy);
        for (int i = 0; i < 4; i++) step(P_D0, 1'b0, 1'b0, E_D0, 1'b0, 3'd0, cy);
        step(P_D1, 1'b0, 1'b0, E_D1, 1'b0, 3'd0, cy);
        for (int i = 0; i < 3; i++) step(P_D2, 1'b0, 1'b0, E_D2, 1'b0, 3'd0, cy);
        step(P_D3, 1'b0, 1'b0, E_D3, 1'b0, 3'd0, cy);
    endtask

    task automatic chk(input string nome, input exp_t e, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s seg %0d step %0d: got %0d, want %0d", nome, e.seg, e.idx, got, want);
        end
    endtask

    // Monitor: compare outputs shortly after each rising edge
    always @(posedge clk) begin
        exp_t e;
        #2;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("fase",     e, int'(fase),     int'(e.fase));
            chk("erro",     e, int'(erro),     int'(e.erro));
            chk("cod_erro", e, int'(cod_erro), int'(e.cod));
            chk("ciclos",   e, int'(ciclos),   int'(e.cy));
        end
    end

    initial begin
        reset = 1'b1;
        modo  = 1'b0;
        lamps = P_D0;

        // Seg 1: legal day run, three full cycles
        seg = 1;
        step(P_D0, 1'b0, 1'b1, E_INV, 1'b0, 3'd0, 8'd0);
        step(P_D0, 1'b0, 1'b1, E_INV, 1'b0, 3'd0, 8'd0);
        legal_cycle(8'd0);
        legal_cycle(8'd1);
        legal_cycle(8'd2);
        step(P_D0, 1'b0, 1'b0, E_D0, 1'b0, 3'd0, 8'd3);

        // Seg 2: both greens during dia2, later faults ignored
        seg = 2;
        for (int i = 0; i < 3; i++) step(P_D0, 1'b0, 1'b0, E_D0, 1'b0, 3'd0, 8'd3);
        step(P_D1, 1'b0, 1'b0, E_D1, 1'b0, 3'd0, 8'd3);
        step(P_D2, 1'b0, 1'b0, E_D2, 1'b0, 3'd0, 8'd3);
        step(P_VV, 1'b0, 1'b0, E_INV, 1'b1, 3'd1, 8'd3);
        step(P_BAD, 1'b0, 1'b0, E_INV, 1'b1, 3'd1, 8'd3);
        step(P_D0, 1'b0, 1'b0, E_D0, 1'b1, 3'd1, 8'd3);

        // Seg 3: short dwell on dia0
        seg = 3;
        step(P_D0, 1'b0, 1'b1, E_INV, 1'b0, 3'd0, 8'd0);
        legal_cycle(8'd0);
        for (int i = 0; i < 3; i++) step(P_D0, 1'b0, 1'b0, E_D0, 1'b0, 3'd0, 8'd1);
        step(P_D1, 1'b0, 1'b0, E_D1, 1'b1, 3'd4, 8'd1);

        // Seg 4: long dwell on dia2
        seg = 4;
        step(P_D0, 1'b0, 1'b1, E_INV, 1'b0, 3'd0, 8'd0);
        for (int i = 0; i < 4; i++) step(P_D0, 1'b0, 1'b0, E_D0, 1'b0, 3'd0, 8'd0);
        step(P_D1, 1'b0, 1'b0, E_D1, 1'b0, 3'd0, 8'd0);
        for (int i = 0; i < 3; i++) step(P_D2, 1'b0, 1'b0, E_D2, 1'b0, 3'd0, 8'd0);
        step(P_D2, 1'b0, 1'b0, E_D2, 1'b1, 3'd5, 8'd0);

        // Seg 5: day->night mode change mid dia0, alternation, then noite0 held
        seg = 5;
        step(P_D0, 1'b0, 1'b1, E_INV, 1'b0, 3'd0, 8'd0);
        step(P_D0, 1'b0, 1'b0, E_D0, 1'b0, 3'd0, 8'd0);
        step(P_D0, 1'b0, 1'b0, E_D0, 1'b0, 3'd0, 8'd0);
        step(P_D0, 1'b1, 1'b0, E_D0, 1'b0, 3'd0, 8'd0);
        step(P_N0, 1'b1, 1'b0, E_N0, 1'b0, 3'd0, 8'd0);
        step(P_N1, 1'b1, 1'b0, E_N1, 1'b0, 3'd0, 8'd0);
        step(P_N0, 1'b1, 1'b0, E_N0, 1'b0, 3'd0, 8'd0);
        step(P_N1, 1'b1, 1'b0, E_N1, 1'b0, 3'd0, 8'd0);
        step(P_N0, 1'b1, 1'b0, E_N0, 1'b0, 3'd0, 8'd0);
        step(P_N0, 1'b1, 1'b0, E_N0, 1'b1, 3'd6, 8'd0);
        step(P_N1, 1'b1, 1'b0, E_N1, 1'b1, 3'd6, 8'd0);

        // Seg 6: mode change coinciding with a bad pattern, resync into dia2
        seg = 6;
        step(P_N0, 1'b1, 1'b1, E_INV, 1'b0, 3'd0, 8'd0);
        step(P_N0, 1'b1, 1'b0, E_N0, 1'b0, 3'd0, 8'd0);
        step(P_N1, 1'b1, 1'b0, E_N1, 1'b0, 3'd0, 8'd0);
        step(P_N0, 1'b1, 1'b0, E_N0, 1'b0, 3'd0, 8'd0);
        step(P_BAD, 1'b0, 1'b0, E_INV, 1'b0, 3'd0, 8'd0);
        step(P_D2, 1'b0, 1'b0, E_D2, 1'b0, 3'd0, 8'd0);
        step(P_D3, 1'b0, 1'b0, E_D3, 1'b0, 3'd0, 8'd0);
        step(P_D0, 1'b0, 1'b0, E_D0, 1'b0, 3'd0, 8'd1);

        // Seg 7: illegal order dia0->dia2, then reset clears everything
        seg = 7;
        step(P_D0, 1'b0, 1'b1, E_INV, 1'b0, 3'd0, 8'd0);
        for (int i = 0; i < 4; i++) step(P_D0, 1'b0, 1'b0, E_D0, 1'b0, 3'd0, 8'd0);
        step(P_D2, 1'b0, 1'b0, E_D2, 1'b1, 3'd3, 8'd0);
        step(P_D2, 1'b0, 1'b1, E_INV, 1'b0, 3'd0, 8'd0);
        step(P_D0, 1'b0, 1'b0, E_D0, 1'b0, 3'd0, 8'd0);

        // Seg 8: ciclos saturates at 255
        seg = 8;
        step(P_D0, 1'b0, 1'b1, E_INV, 1'b0, 3'd0, 8'd0);
        for (int i = 0; i <= 256; i++) legal_cycle((i > 255) ? 8'd255 : 8'(i));
        step(P_D0, 1'b0, 1'b0, E_D0, 1'b0, 3'd0, 8'd255);

        for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
        #5;
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
